// File: rtl/fsrc_seq_pkg.sv
// FSRC sequencer shared types.
// State encoding, shadow config bundle, default widths.
package fsrc_seq_pkg;

  localparam int DEF_CTRL_WIDTH    = 40;
  localparam int DEF_COUNTER_WIDTH = 4;
  localparam int DEF_NUM_TRIG      = 4;
  localparam int DEF_PW_WIDTH      = 4;
  localparam int DEF_REPEAT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    FLUSH
  } fsrc_seq_state_t;

  typedef struct packed {
    logic [DEF_CTRL_WIDTH-1:0]                  next_ctrl;
    logic [DEF_COUNTER_WIDTH-1:0]               ctrl_cnt;
    logic [DEF_NUM_TRIG-1:0]                    en;
    logic [DEF_NUM_TRIG*DEF_COUNTER_WIDTH-1:0]  tcnt;
    logic [DEF_NUM_TRIG*DEF_PW_WIDTH-1:0]       twidth;
    logic [DEF_COUNTER_WIDTH-1:0]               end_cnt;
    logic [DEF_REPEAT_WIDTH-1:0]                rep;
  } fsrc_seq_cfg_t;

endpackage

// File: rtl/fsrc_seq_ctrl_mc_if.sv
// FSRC sequencer control/status bundle.
// master drives config and commands, slave is the sequencer.
interface fsrc_seq_ctrl_mc_if
  import fsrc_seq_pkg::*;
#(
  parameter int CTRL_WIDTH    = DEF_CTRL_WIDTH,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int NUM_TRIG      = DEF_NUM_TRIG,
  parameter int PW_WIDTH      = DEF_PW_WIDTH,
  parameter int REPEAT_WIDTH  = DEF_REPEAT_WIDTH
);
  logic                              start;
  logic                              ext_trig_in;
  logic                              ext_trig_en;
  logic                              abort;
  logic [CTRL_WIDTH-1:0]             next_ctrl_value;
  logic [COUNTER_WIDTH-1:0]          ctrl_change_cnt;
  logic [NUM_TRIG-1:0]               trig_en;
  logic [NUM_TRIG*COUNTER_WIDTH-1:0] trig_cnt;
  logic [NUM_TRIG*PW_WIDTH-1:0]      trig_width;
  logic [COUNTER_WIDTH-1:0]          end_cnt;
  logic [REPEAT_WIDTH-1:0]           repeat_cnt;
  logic [CTRL_WIDTH-1:0]             ctrl_out;
  logic                              ctrl_update;
  logic [NUM_TRIG-1:0]               trig_out;
  logic                              tx_data_start;
  logic                              busy;
  logic                              done;
  logic                              start_err;

  modport master (
    output start, ext_trig_in, ext_trig_en, abort,
    output next_ctrl_value, ctrl_change_cnt,
    output trig_en, trig_cnt, trig_width,
    output end_cnt, repeat_cnt,
    input  ctrl_out, ctrl_update, trig_out,
    input  tx_data_start, busy, done, start_err
  );

  modport slave (
    input  start, ext_trig_in, ext_trig_en, abort,
    input  next_ctrl_value, ctrl_change_cnt,
    input  trig_en, trig_cnt, trig_width,
    input  end_cnt, repeat_cnt,
    output ctrl_out, ctrl_update, trig_out,
    output tx_data_start, busy, done, start_err
  );

endinterface

// File: rtl/fsrc_seq_ctrl_mc_trig_stretch.sv
// Loadable down-counter pulse stretcher.
// A zero width still yields a single-cycle pulse.
module fsrc_trig_stretch #(
  parameter int PW_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [PW_WIDTH-1:0] width_i,
  output logic                pulse_o
);

  logic [PW_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= (width_i == '0) ? PW_WIDTH'(1) : width_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign pulse_o = |cnt_q;

endmodule

// File: rtl/fsrc_seq_ctrl_mc.sv
// SYSREF-epoch FSRC sequencer: ctrl word, triggers, tx start.
// Supports repeat passes, abort and start rejection.
module fsrc_seq_ctrl_mc
  import fsrc_seq_pkg::*;
#(
  parameter int CTRL_WIDTH    = DEF_CTRL_WIDTH,
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int NUM_TRIG      = DEF_NUM_TRIG,
  parameter int PW_WIDTH      = DEF_PW_WIDTH,
  parameter int REPEAT_WIDTH  = DEF_REPEAT_WIDTH,
  parameter logic [CTRL_WIDTH-1:0] CTRL_RESET = '0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      sysref_int,
  fsrc_seq_ctrl_mc_if.slave bus
);

  fsrc_seq_state_t          state_q;
  fsrc_seq_cfg_t            cfg_q;
  logic [COUNTER_WIDTH-1:0] count_q;
  logic [REPEAT_WIDTH-1:0]  iter_q;
  logic [CTRL_WIDTH-1:0]    ctrl_q;
  logic                     upd_q;
  logic                     txs_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;
  logic                     ext_q;
  logic [NUM_TRIG-1:0]      trig;
  logic [NUM_TRIG-1:0]      load;
  logic                     start_ev;
  logic                     abort_v;
  logic                     epoch;

  assign start_ev = bus.ext_trig_en ? (bus.ext_trig_in & ~ext_q)
                                    : bus.start;
  assign abort_v  = bus.abort & (state_q != IDLE);
  assign epoch    = sysref_int &
                    ((state_q == ARMED) | (state_q == RUN));

  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_trig
    assign load[g] = epoch & cfg_q.en[g] &
      (count_q == cfg_q.tcnt[g*COUNTER_WIDTH +: COUNTER_WIDTH]);

    fsrc_trig_stretch #(
      .PW_WIDTH (PW_WIDTH)
    ) u_stretch (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (abort_v),
      .load_i  (load[g]),
      .width_i (cfg_q.twidth[g*PW_WIDTH +: PW_WIDTH]),
      .pulse_o (trig[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      count_q <= '0;
      iter_q  <= '0;
      ctrl_q  <= CTRL_RESET;
      upd_q   <= 1'b0;
      txs_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ext_q   <= 1'b0;
    end else begin
      ext_q  <= bus.ext_trig_in;
      upd_q  <= 1'b0;
      txs_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort_v) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        count_q <= '0;
        iter_q  <= '0;
      end else begin
        err_q <= start_ev & (state_q != IDLE);
        unique case (state_q)
          IDLE: if (start_ev) begin
            cfg_q.next_ctrl <= bus.next_ctrl_value;
            cfg_q.ctrl_cnt  <= bus.ctrl_change_cnt;
            cfg_q.en        <= bus.trig_en;
            cfg_q.tcnt      <= bus.trig_cnt;
            cfg_q.twidth    <= bus.trig_width;
            cfg_q.end_cnt   <= bus.end_cnt;
            cfg_q.rep       <= bus.repeat_cnt;
            count_q <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ARMED;
          end
          ARMED, RUN: if (epoch) begin
            state_q <= RUN;
            if (count_q == cfg_q.ctrl_cnt) begin
              ctrl_q <= cfg_q.next_ctrl;
              upd_q  <= 1'b1;
            end
            // count stops at end_cnt, so later events never match
            if (count_q == cfg_q.end_cnt) begin
              txs_q <= 1'b1;
              if (iter_q < cfg_q.rep) begin
                iter_q  <= iter_q + 1'b1;
                count_q <= '0;
              end else begin
                state_q <= FLUSH;
              end
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
          FLUSH: if (trig == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ctrl_out      = ctrl_q;
  assign bus.ctrl_update   = upd_q;
  assign bus.trig_out      = trig;
  assign bus.tx_data_start = txs_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.start_err     = err_q;

endmodule

// File: doc/fsrc_seq_ctrl_mc.md
Name: fsrc_seq_ctrl_mc

Overview:
- Next-generation FSRC sequencer. It replaces fixed-width trigger stretching and one-shot operation with per-trigger enables and widths, programmable repeat, abort, ctrl-word update and status.
- All events are timed in sysref_int epochs, so TX FSRC control words, triggers and tx_data_start align to SYSREF across the datapath.
- Single clock domain; sysref_int is a 1-cycle strobe already synchronous to clk.

Parameters:
- CTRL_WIDTH, 40, width of the ctrl word.
- COUNTER_WIDTH, 4, epoch counter width.
- NUM_TRIG, 4, number of trigger outputs.
- PW_WIDTH, 4, trigger pulse-width field width.
- REPEAT_WIDTH, 8, repeat count width.
- CTRL_RESET, 0, ctrl_out reset value.

Ports:
- clk  in  1  clock.
- reset  in  1  reset: synchronous, active-high.
- sysref_int  in  1  epoch strobe, 1 cycle wide.
- start  in  1  regmap start pulse.
- ext_trig_in  in  1  external start level; the rising edge is used.
- ext_trig_en  in  1  1 selects the ext_trig_in edge as start source, 0 selects start.
- abort  in  1  abort pulse.
- next_ctrl_value  in  CTRL_WIDTH  ctrl word to apply.
- ctrl_change_cnt  in  COUNTER_WIDTH  epoch at which ctrl_out updates.
- trig_en  in  NUM_TRIG  per-trigger enable.
- trig_cnt  in  NUM_TRIG*COUNTER_WIDTH  per-trigger fire epoch.
- trig_width  in  NUM_TRIG*PW_WIDTH  per-trigger pulse width in clk cycles.
- end_cnt  in  COUNTER_WIDTH  last epoch of an iteration; tx_data_start fires here.
- repeat_cnt  in  REPEAT_WIDTH  extra iterations; 0 means one pass.
- ctrl_out  out  CTRL_WIDTH  applied ctrl word.
- ctrl_update  out  1  1-cycle strobe on ctrl_out change.
- trig_out  out  NUM_TRIG  trigger pulses.
- tx_data_start  out  1  1-cycle pulse.
- busy  out  1  high while the sequence is active.
- done  out  1  1-cycle completion pulse.
- start_err  out  1  1-cycle pulse when a start is rejected.

Behaviour:
- Reset values: ctrl_out=CTRL_RESET; all other outputs 0; state IDLE; count=0; iter=0.
- start_ev = ext_trig_en ? (ext_trig_in & ~ext_trig_in_d) : start. ext_trig_in_d is registered with reset.
- States: IDLE, ARMED, RUN, FLUSH.
- IDLE, start_ev: latch all config inputs into shadow regs; count=0; iter=0; go to ARMED. busy=1 from the next cycle.
- start_ev outside IDLE: ignored; start_err pulses 1 cycle later.
- ARMED: the first sysref_int strictly after acceptance is epoch 0. A sysref_int coincident with acceptance is ignored. Go to RUN.
- Each epoch (sysref_int in ARMED/RUN) evaluates matches on the current count, using shadow values only:
  - e==ctrl_change_cnt: ctrl_out<=next_ctrl; ctrl_update=1.
  - trig_en[i] && e==trig_cnt[i]: load stretcher i.
  - e==end_cnt: tx_data_start=1.
- Latency: all epoch-driven outputs assert exactly 1 clk after the sysref_int cycle.
- Epoch counting:
  - After evaluating epoch e<end_cnt: count<=e+1.
  - At e==end_cnt with iter<repeat_cnt: iter++, count<=0; the next sysref is epoch 0 of the next pass.
  - At e==end_cnt with iter==repeat_cnt: go to FLUSH.
  - count never exceeds end_cnt, so it never wraps. Events with cnt>end_cnt never fire.
- FLUSH: waits until trig_out==0, then done=1 for 1 cycle, busy=0 and state IDLE in the same cycle. sysref_int is ignored in FLUSH.
- Stretcher:
  - trig_out[i] is high for max(trig_width[i],1) cycles.
  - A reload while active restarts the full width; no gap.
- abort (any state except IDLE): next cycle state=IDLE, trig_out=0, busy=0, count=0, iter=0. done is not asserted.
  - ctrl_out keeps its value.
  - abort has priority over start_ev and sysref_int in the same cycle. No start_err is raised for that start.
  - abort in IDLE is a no-op.
- Live config input changes during a sequence have no effect; they apply at the next accepted start.
- Reset mid-sequence: all state returns to reset values in the next cycle, including ctrl_out.

Decomposition:
- Package fsrc_seq_pkg:
  - state enum typedef fsrc_seq_state_t {IDLE, ARMED, RUN, FLUSH};
  - shadow-config struct typedef;
  - default width constants.
- Sub-module fsrc_trig_stretch: loadable PW_WIDTH down-counter pulse stretcher, instantiated NUM_TRIG times.

Test Plan:
- Basic, one pass:
  - Config: ctrl_change_cnt=1, trig_cnt={3,2,1,0}, trig_width={4,1,2,3}, trig_en=4'hF, end_cnt=5, repeat_cnt=0; sysref every 16 clks.
  - Response: ctrl_update and each trigger fire 1 clk after their epoch's sysref, with exact widths; tx_data_start 1 clk after epoch 5.
  - done fires once trig_out is low; busy spans from acceptance to done.
- Repeat: repeat_cnt=2, end_cnt=3 -> exactly 3 tx_data_start pulses, each 4 epochs apart; 3 ctrl_update strobes; 1 done.
- Rejection and source select:
  - Second start while RUN -> start_err pulse; sequence unchanged.
  - ext_trig_en=1 with ext_trig_in held high -> only one acceptance.
  - With ext_trig_en=1, pulses on start are ignored.
- Abort during RUN at epoch 2 with trig_width=8 active -> trig_out=0 and busy=0 next clk; no done; ctrl_out retained.
- Boundaries:
  - sysref_int coincident with start -> epoch 0 is the next sysref.
  - trig_width=0 -> 1-cycle pulse.
  - trig_cnt>end_cnt -> never fires.
  - trig_cnt equal across two triggers -> simultaneous pulses.
- Reset mid-FLUSH -> all outputs 0, ctrl_out=CTRL_RESET; a new start behaves as in the basic scenario.
